npc_lsu: RTL and testbench

- Load/store initiator between the execute stage and the 64-bit data-memory port (pmem DPI memory: raddr/rdata/waddr/wdata/wmask/MemWrite).
- Accepts one load or store per handshake and aligns the address to 8 bytes.
- Drives byte-lane masked writes and extracts/extends load data.
- Reports misaligned and timed-out accesses as errors; single outstanding request.

---
 rtl/npc_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_npc_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/npc_lsu.sv
// Load/store unit between the execute stage and the 64-bit data memory port.
// One request in flight; handles lane alignment, load extension, misalignment and timeout errors.
module npc_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic           wen_q, wen_d;
  logic [63:0]    addr_q, addr_d;
  logic [63:0]    wdata_q, wdata_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  function automatic logic misaligned_f(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off[2:0];
    endcase
    return mis;
  endfunction

  function automatic logic [7:0] lane_mask_f(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Shift the addressed lanes down, keep the access width, then sign/zero extend.
  function automatic logic [63:0] load_extend_f(input logic [63:0] raw, input logic [2:0] off,
                                                input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [63:0] res;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    res = {{56{~uns & sh[7]}},  sh[7:0]};
      2'd1:    res = {{48{~uns & sh[15]}}, sh[15:0]};
      2'd2:    res = {{32{~uns & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // State register and latched request/response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          cnt_d   = '0;
          rdata_d = 64'd0;
          if (misaligned_f(req_addr[2:0], req_size)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          rdata_d = wen_q ? 64'd0 : load_extend_f(mem_rdata, addr_q[2:0], size_q, uns_q);
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          // TIMEOUT consecutive cycles without mem_ready have now elapsed.
          rdata_d = 64'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ACCESS;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_raddr  = 64'd0;
    mem_waddr  = 64'd0;
    mem_wdata  = 64'd0;
    mem_wmask  = 8'd0;
    mem_wen    = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 64'd0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      ACCESS: begin
        mem_valid = 1'b1;
        mem_raddr = {addr_q[63:3], 3'b000};
        mem_waddr = {addr_q[63:3], 3'b000};
        mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
        mem_wmask = lane_mask_f(size_q) << addr_q[2:0];
        mem_wen   = wen_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_npc_lsu.sv
// Directed bench for npc_lsu: stores, loads with extension, misalignment, timeout,
// response backpressure and reset during an access.
module tb_npc_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_wen;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int checks;
  int failures;

  npc_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; outputs afterwards reflect the accepted request.
  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    step();
    req_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0h exp=1", req_ready); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%0h exp=0", mem_valid); end
    checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL reset_mem_wen got=%0h exp=0", mem_wen); end
    checks++; if (mem_wmask !== 8'h00) begin failures++; $display("FAIL reset_mem_wmask got=%0h exp=0", mem_wmask); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0h exp=0", resp_valid); end
    checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp got=%0h/%0h exp=0/0", resp_rdata, resp_err); end
  endtask

  task automatic test_store_byte();
    mem_ready  = 1'b1;
    resp_ready = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    issue(1'b1, 64'h8000_0003, 64'h0000_0000_0000_00AB, 2'd0, 1'b0);
    checks++; if (mem_valid !== 1'b1 || mem_wen !== 1'b1) begin failures++; $display("FAIL sb_strobe got=%0h/%0h exp=1/1", mem_valid, mem_wen); end
    checks++; if (mem_waddr !== 64'h8000_0000 || mem_raddr !== 64'h8000_0000) begin failures++; $display("FAIL sb_addr got=%0h/%0h exp=80000000", mem_waddr, mem_raddr); end
    checks++; if (mem_wmask !== 8'h08) begin failures++; $display("FAIL sb_wmask got=%0h exp=08", mem_wmask); end
    checks++; if (mem_wdata !== 64'h0000_0000_AB00_0000) begin failures++; $display("FAIL sb_wdata got=%0h exp=ab000000", mem_wdata); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL sb_req_ready got=%0h exp=0", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin failures++; $display("FAIL sb_resp got=%0h/%0h/%0h exp=1/0/0", resp_valid, resp_err, resp_rdata); end
    checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0 || mem_wdata !== 64'd0) begin failures++; $display("FAIL sb_mem_idle got=%0h/%0h/%0h exp=0/0/0", mem_valid, mem_wen, mem_wdata); end
    step();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL sb_back_idle got=%0h/%0h exp=1/0", req_ready, resp_valid); end
  endtask

  task automatic test_load_half();
    mem_ready  = 1'b1;
    resp_ready = 1'b1;
    mem_rdata  = 64'h8001_0000_0000_0000;
    issue(1'b0, 64'h8000_0006, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0);
    checks++; if (mem_wen !== 1'b0 || mem_wmask !== 8'hC0) begin failures++; $display("FAIL lh_access got=%0h/%0h exp=0/c0", mem_wen, mem_wmask); end
    step();
    checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_8001 || resp_err !== 1'b0) begin failures++; $display("FAIL lh_signed got=%0h exp=ffffffffffff8001", resp_rdata); end
    step();
    issue(1'b0, 64'h8000_0006, 64'd0, 2'd1, 1'b1);
    step();
    checks++; if (resp_rdata !== 64'h0000_0000_0000_8001) begin failures++; $display("FAIL lh_unsigned got=%0h exp=8001", resp_rdata); end
    step();
  endtask

  task automatic test_load_misc();
    mem_ready  = 1'b1;
    resp_ready = 1'b1;
    mem_rdata  = 64'h7654_3210_DEAD_BEEF;
    issue(1'b0, 64'h8000_0004, 64'd0, 2'd2, 1'b0);
    checks++; if (mem_wmask !== 8'hF0 || mem_raddr !== 64'h8000_0000) begin failures++; $display("FAIL lw_access got=%0h/%0h exp=f0/80000000", mem_wmask, mem_raddr); end
    step();
    checks++; if (resp_rdata !== 64'h0000_0000_7654_3210) begin failures++; $display("FAIL lw_off4 got=%0h exp=76543210", resp_rdata); end
    step();
    mem_rdata = 64'h0000_0000_0000_8500;
    issue(1'b0, 64'h8000_0001, 64'd0, 2'd0, 1'b0);
    step();
    checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FF85) begin failures++; $display("FAIL lb_signed got=%0h exp=ffffffffffffff85", resp_rdata); end
    step();
    mem_rdata = 64'h8123_4567_89AB_CDEF;
    issue(1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b1);
    checks++; if (mem_raddr !== 64'h8000_0008 || mem_wmask !== 8'hFF) begin failures++; $display("FAIL ld_access got=%0h/%0h exp=80000008/ff", mem_raddr, mem_wmask); end
    step();
    checks++; if (resp_rdata !== 64'h8123_4567_89AB_CDEF) begin failures++; $display("FAIL ld_double got=%0h exp=8123456789abcdef", resp_rdata); end
    step();
  endtask

  task automatic test_misaligned();
    mem_ready  = 1'b1;
    resp_ready = 1'b1;
    mem_rdata  = 64'hAAAA_BBBB_CCCC_DDDD;
    issue(1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0);
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL mis_mem_valid got=%0h exp=0", mem_valid); end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 64'd0) begin failures++; $display("FAIL mis_resp got=%0h/%0h/%0h exp=1/1/0", resp_valid, resp_err, resp_rdata); end
    step();
    issue(1'b1, 64'h8000_0001, 64'h1234, 2'd1, 1'b0);
    checks++; if (mem_wen !== 1'b0 || resp_err !== 1'b1) begin failures++; $display("FAIL mis_store got=%0h/%0h exp=0/1", mem_wen, resp_err); end
    step();
  endtask

  task automatic test_timeout();
    mem_ready  = 1'b0;
    resp_ready = 1'b1;
    mem_rdata  = 64'h5555_6666_7777_8888;
    issue(1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL to_mem_valid cycle=%0d got=%0h exp=1", i, mem_valid); end
      step();
    end
    checks++; if (mem_valid !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1) begin failures++; $display("FAIL to_resp got=%0h/%0h/%0h exp=0/1/1", mem_valid, resp_valid, resp_err); end
    checks++; if (resp_rdata !== 64'd0) begin failures++; $display("FAIL to_rdata got=%0h exp=0", resp_rdata); end
    mem_ready = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    mem_ready  = 1'b1;
    resp_ready = 1'b0;
    mem_rdata  = 64'hF123_4567_0000_0000;
    issue(1'b0, 64'h8000_0004, 64'd0, 2'd2, 1'b0);
    step();
    mem_rdata = 64'd0;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 64'h8000_0000;
    req_size  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cycle=%0d got=%0h/%0h exp=1/0", i, resp_valid, req_ready); end
      checks++; if (resp_rdata !== 64'hFFFF_FFFF_F123_4567 || resp_err !== 1'b0) begin failures++; $display("FAIL bp_data cycle=%0d got=%0h exp=fffffffff1234567", i, resp_rdata); end
      step();
    end
    resp_ready = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1 || mem_valid !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL bp_no_accept got=%0h/%0h/%0h exp=1/0/0", req_ready, mem_valid, resp_valid); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_ready  = 1'b0;
    resp_ready = 1'b1;
    issue(1'b1, 64'h8000_0020, 64'h99, 2'd0, 1'b0);
    checks++; if (mem_valid !== 1'b1 || mem_wen !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0h/%0h exp=1/1", mem_valid, mem_wen); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0) begin failures++; $display("FAIL rm_mem got=%0h/%0h exp=0/0", mem_valid, mem_wen); end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rm_idle got=%0h/%0h exp=1/0", req_ready, resp_valid); end
    mem_ready = 1'b1;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    issue(1'b0, 64'h8000_0000, 64'd0, 2'd3, 1'b0);
    step();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL rm_after got=%0h/%0h/%0h exp=1/0/123456789abcdef", resp_valid, resp_err, resp_rdata); end
    step();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_wen      = 1'b0;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    mem_ready    = 1'b1;
    mem_rdata    = 64'd0;
    resp_ready   = 1'b1;
    test_reset();
    test_store_byte();
    test_load_half();
    test_load_misc();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
